// File: rtl/rca_sched_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
`timescale 1ns/1ps
package rca_sched_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rca_serial_add_sched_fa4_slice.sv
// fa4_slice: combinational 4-bit ripple-carry adder. Four single-bit full-adder
// cells are chained, and the carry ripples from bit 0 up to bit 3.
`timescale 1ns/1ps
module fa4_slice
   import rca_sched_pkg::*;
(
   input  logic [SLICE_W-1:0] a4,
   input  logic [SLICE_W-1:0] b4,
   input  logic               ci,
   output logic [SLICE_W-1:0] s4,
   output logic               co
);

   logic [SLICE_W:0] c_w;

   assign c_w[0] = ci;

   // One full-adder cell per bit, with the carry chained to the next cell.
   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      assign s4[i]    = a4[i] ^ b4[i] ^ c_w[i];
      assign c_w[i+1] = (a4[i] & b4[i]) | (c_w[i] & (a4[i] ^ b4[i]));
   end

   assign co = c_w[SLICE_W];

endmodule

// File: rtl/rca_serial_add_sched.sv
// rca_serial_add_sched: WIDTH-bit add done one nibble per clock through a single
// 4-bit ripple slice. The carry between nibbles is held in a register.
// Optional macro SUB_EN adds the op_sub port. When op_sub is 1, the block
// computes a - b by capturing ~b and forcing the carry-in to 1.
//
//  state | meaning
//  IDLE  | waiting for operands, in_ready high
//  RUN   | one nibble added per cycle, idx selects the nibble
//  DONE  | result held, out_valid high until out_ready
`timescale 1ns/1ps
module rca_serial_add_sched
   import rca_sched_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SUB_EN
   input  logic             op_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

   state_t             state_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   sum_q;
   logic               carry_q;
   logic               cout_q;
   logic [IDX_W-1:0]   idx_q;
   logic [IDX_W-1:0]   idx_d;
   logic               sub_w;
   logic [WIDTH-1:0]   b_d;
   logic               carry_d;
   logic [SLICE_W-1:0] slice_s;
   logic               slice_co;

`ifdef SUB_EN
   assign sub_w = op_sub;
`else
   assign sub_w = 1'b0;
`endif

   // When subtracting, capture the inverted b and a forced carry-in of 1.
   // Together these form the two's-complement negation of b.
   assign b_d     = sub_w ? ~b : b;
   assign carry_d = sub_w | cin;
   assign idx_d   = idx_q + 1'b1;

   fa4_slice u_slice (
      .a4 (a_q[SLICE_W*idx_q +: SLICE_W]),
      .b4 (b_q[SLICE_W*idx_q +: SLICE_W]),
      .ci (carry_q),
      .s4 (slice_s),
      .co (slice_co)
   );

   // Sequencer: capture the operands, step through the nibbles, then hold the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b_d;
                  carry_q <= carry_d;
                  idx_q   <= '0;
                  sum_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q[SLICE_W*idx_q +: SLICE_W] <= slice_s;
               carry_q <= slice_co;
               if (idx_q == IDX_LAST) begin
                  cout_q  <= slice_co;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_d;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_rca_serial_add_sched.sv
// Directed and random checks of the nibble-serial adder against a reference
// model that uses plain integer arithmetic.
`timescale 1ns/1ps
module tb_rca_serial_add_sched;

   localparam int WIDTH  = 16;
   localparam int NSLICE = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             cin = 1'b0;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
`ifdef SUB_EN
   logic             op_sub = 1'b0;
`endif
   logic             in_ready;
   logic             out_valid;
   logic             cout;
   logic             busy;
   logic [WIDTH-1:0] sum;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rca_serial_add_sched #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SUB_EN
      .op_sub    (op_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference result as {cout, sum}.
   // Subtraction gives the wrapped difference, with cout meaning "no borrow".
   function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c, input logic s);
      int t;
      logic [WIDTH-1:0] d;
      if (s) begin
         d = x - y;
         return {(x >= y), d};
      end
      t = 0;
      t = t + int'(x);
      t = t + int'(y);
      t = t + int'(c);
      return t[WIDTH:0];
   endfunction

   // One transaction. If stall > 0, out_ready is held low that many cycles after
   // out_valid. During the stall the producer offers (na, nb), which must be ignored.
   task automatic do_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tc, input logic ts, input int stall,
                        input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb);
      logic [WIDTH:0] exp;
      logic eff_sub;
      int lat;
      int nbusy;
`ifdef SUB_EN
      eff_sub = ts;
`else
      eff_sub = 1'b0;
`endif
      exp = ref_op(ta, tb_v, tc, eff_sub);
      @(negedge clk);
      check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
      a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = (stall == 0);
`ifdef SUB_EN
      op_sub = ts;
`endif
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
`ifdef SUB_EN
      op_sub = 1'($urandom);
`endif
      check({tag, ".sum_clr"}, 32'(sum), 32'd0);
      nbusy = busy ? 1 : 0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (busy) nbusy++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(NSLICE));
      check({tag, ".busy_cycles"}, 32'(nbusy), 32'(NSLICE));
      check({tag, ".sum"}, 32'(sum), 32'(exp[WIDTH-1:0]));
      check({tag, ".cout"}, 32'(cout), 32'(exp[WIDTH]));
      check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
      if (stall > 0) begin
         a = na; b = nb; in_valid = 1'b1;
         for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".stall_sum"}, 32'({cout, sum}), 32'(exp));
            check({tag, ".stall_in_ready"}, 32'(in_ready), 32'd0);
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, ".back_idle"}, 32'(in_ready), 32'd1);
      check({tag, ".idle_hold"}, 32'({cout, sum}), 32'(exp));
   endtask

   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic rs;
      int seen;

      // Reset state.
      #12;
      check("rst.in_ready", 32'(in_ready), 32'd1);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.sum", 32'(sum), 32'd0);
      check("rst.cout", 32'(cout), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Directed cases from the plan.
      do_op("add_1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 0, '0, '0);
      do_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, '0, '0);
      do_op("add_ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, '0, '0);
      do_op("add_0_cin", 16'h0000, 16'h0000, 1'b1, 1'b0, 0, '0, '0);

      // Backpressure. The offered second pair must wait and then be processed normally.
      do_op("bp_first", 16'hA5A5, 16'h1111, 1'b0, 1'b0, 5, 16'h0F00, 16'h00F0);
      do_op("bp_second", 16'h0F00, 16'h00F0, 1'b0, 1'b0, 0, '0, '0);

      // Reset partway through RUN aborts the transaction.
      @(negedge clk);
      a = 16'h7777; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort.busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0; #1;
      check("abort.in_ready", 32'(in_ready), 32'd1);
      check("abort.sum", 32'(sum), 32'd0);
      check("abort.busy", 32'(busy), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("abort.no_result", 32'(seen), 32'd0);
      check("abort.sum_after", 32'(sum), 32'd0);
      do_op("post_abort", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 0, '0, '0);

`ifdef SUB_EN
      do_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, '0, '0);
      do_op("sub_7_5", 16'h0007, 16'h0005, 1'b1, 1'b1, 0, '0, '0);
`endif

      // Random transactions.
      for (int i = 0; i < 20; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         rs = 1'($urandom);
         do_op("rand", ra, rb, 1'($urandom), rs, (i % 5 == 4) ? 2 : 0, ra ^ rb, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
